// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding plus the frame constants
// common to the rx/tx blocks.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_START_BITS = 1;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_FRAME_BITS = UART_START_BITS + UART_DATA_BITS + UART_STOP_BITS;

  localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
  localparam logic [2:0] ST_LOCK_ENC      = 3'd1;
  localparam logic [2:0] ST_START_ENC     = 3'd2;
  localparam logic [2:0] ST_BUSY_WAIT_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_WAIT_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_LOCK      = ST_LOCK_ENC,
    ST_START     = ST_START_ENC,
    ST_BUSY_WAIT = ST_BUSY_WAIT_ENC,
    ST_DONE_WAIT = ST_DONE_WAIT_ENC
  } arb_state_e;

  // Index wrap for a search that starts below n and advances by less than n.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any,
  output logic [PTR_W-1:0]   idx
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'(wrap_idx(int'(ptr) + k, NUM_REQ));
      if (!any && req[cand]) begin
        any          = 1'b1;
        winner[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter; a grant is held for a
// whole message and dropped early only by the inter-byte gap timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_TIMEOUT = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [8*NUM_REQ-1:0]      req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_start,
  output logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_busy,
  output logic                      gap_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  arb_state_e                state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d, owner_q, owner_d;
  logic [PTR_W-1:0]          pick_idx, sel_idx;
  logic [NUM_REQ-1:0]        grant_q, grant_d, pick_onehot, ready_c;
  logic                      pick_any, accept;
  logic                      last_q, last_d, gap_err_q, gap_err_d;
  logic [UART_DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [GAP_W-1:0]          gap_q, gap_d;

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .winner(pick_onehot),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] o);
    if (o == PTR_W'(NUM_REQ - 1)) return '0;
    return o + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    gap_d     = gap_q;
    gap_err_d = 1'b0;
    ready_c   = '0;
    accept    = 1'b0;
    sel_idx   = (state_q == ST_IDLE) ? pick_idx : owner_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any && !tx_busy) begin
          ready_c = pick_onehot;
          accept  = 1'b1;
          owner_d = pick_idx;
          grant_d = pick_onehot;
          state_d = ST_START;
        end
      end
      ST_START:     state_d = ST_BUSY_WAIT;
      ST_BUSY_WAIT: if (tx_busy) state_d = ST_DONE_WAIT;
      ST_DONE_WAIT: begin
        if (!tx_busy) begin
          if (last_q) begin
            ptr_d   = ptr_after(owner_q);
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d   = '0;
            state_d = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        if (req_valid[owner_q] && !tx_busy) begin
          ready_c[owner_q] = 1'b1;
          accept           = 1'b1;
          state_d          = ST_START;
        end else begin
          if (gap_q != '1) gap_d = gap_q + 1'b1;
          // gap_q counts completed idle cycles; this one brings it to the limit
          if (gap_q >= GAP_LAST) begin
            gap_err_d = 1'b1;
            ptr_d     = ptr_after(owner_q);
            grant_d   = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      tx_data_d = req_data[{sel_idx, 3'b000} +: UART_DATA_BITS];
      last_d    = req_last[sel_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      gap_q     <= '0;
      gap_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      gap_err_q <= gap_err_d;
    end
  end

  // Ready is combinational from state, so it is forced low while reset is held.
  assign req_ready = ready_c & {NUM_REQ{rst_n}};
  assign grant     = grant_q;
  assign tx_start  = (state_q == ST_START);
  assign tx_data   = tx_data_q;
  assign gap_err   = gap_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand sequences and randomized
// message traffic scored against a message-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready, grant;
  logic           tx_start, tx_busy, gap_err;
  logic [7:0]     tx_data;

  logic force_busy  = 1'b0;
  logic tx_model_en = 1'b1;
  int   busy_len    = 4;
  int   busy_cnt    = 0;

  int n_checks    = 0;
  int n_pass      = 0;
  int onehot_viol = 0;
  int m_ptr       = 0;

  typedef struct { logic [7:0] d; logic l; } byte_t;
  typedef struct { int o; logic [7:0] d; } txb_t;
  typedef struct {
    logic [N-1:0] valid;
    logic         busy;
    logic [N-1:0] exp_ready;
    logic [7:0]   exp_data;
  } vec_t;

  byte_t rq [N][$];
  txb_t  exq[$];
  int    owners[$];
  int    start_at[N];

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_TIMEOUT(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .gap_err  (gap_err)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for busy_len cycles after each start pulse.
  always @(posedge clk) begin
    if (tx_start && tx_model_en) busy_cnt <= busy_len;
    else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    force_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      start_at[i] = 0;
    end
    exq.delete();
    rst_n = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic add_msg(input int i, input int len);
    for (int b = 0; b < len; b++) rq[i].push_back('{d: 8'($urandom), l: (b == len - 1)});
  endtask

  // Message-level model: every requester with a pending message is always
  // valid, so messages leave in round-robin order starting after the last owner.
  function automatic void build_expected();
    byte_t mq [N][$];
    bit    more;
    for (int i = 0; i < N; i++) mq[i] = rq[i];
    more = 1'b1;
    while (more) begin
      int w;
      w = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && mq[i].size() > 0) w = i;
      end
      if (w < 0) more = 1'b0;
      else begin
        byte_t b;
        do begin
          b = mq[w].pop_front();
          exq.push_back('{o: w, d: b.d});
        end while (!b.l && mq[w].size() > 0);
        m_ptr = (w + 1) % N;
      end
    end
  endfunction

  task automatic run_traffic(input int limit);
    int           cyc;
    logic [N-1:0] rdy;
    txb_t         e;
    bit           all_empty;
    cyc = 0;
    owners.delete();
    while (cyc < limit) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0 && cyc >= start_at[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq[i][0].d;
          req_last[i]        = rq[i][0].l;
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      #1;
      rdy = req_ready;
      if ($countones(rdy) > 1) onehot_viol++;
      if (tx_start) begin
        if (exq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_tx_start: got byte 0x%0h, required no start", tx_data);
        end else begin
          e = exq.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.d));
          check("grant at tx_start", 32'(grant), 32'(1 << e.o));
          owners.push_back($clog2(grant));
        end
      end
      all_empty = 1'b1;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) all_empty = 1'b0;
      if (all_empty && exq.size() == 0 && grant == '0) break;
      tick();
      for (int i = 0; i < N; i++) if (rdy[i] && req_valid[i]) void'(rq[i].pop_front());
      cyc++;
    end
    check("traffic finished within budget", 32'(cyc < limit), 32'd1);
    clear_inputs();
  endtask

  initial begin
    vec_t vt[8];
    int   k;
    bit   seen;
    logic [N-1:0] leak;
    int   exp_own[4];

    vt[0] = '{4'b0000, 1'b0, 4'b0000, 8'h00};
    vt[1] = '{4'b0001, 1'b0, 4'b0001, 8'hA1};
    vt[2] = '{4'b1010, 1'b0, 4'b0010, 8'hB2};
    vt[3] = '{4'b1000, 1'b0, 4'b1000, 8'hD4};
    vt[4] = '{4'b1111, 1'b0, 4'b0001, 8'hA1};
    vt[5] = '{4'b0110, 1'b0, 4'b0010, 8'hB2};
    vt[6] = '{4'b1111, 1'b1, 4'b0000, 8'h00};
    vt[7] = '{4'b0100, 1'b1, 4'b0000, 8'h00};

    // Reset state
    do_reset();
    check("reset grant", 32'(grant), 0);
    check("reset tx_start", 32'(tx_start), 0);
    check("reset tx_data", 32'(tx_data), 0);
    check("reset gap_err", 32'(gap_err), 0);
    check("reset req_ready", 32'(req_ready), 0);

    // IDLE pick table from ptr=0
    for (int v = 0; v < 8; v++) begin
      do_reset();
      req_valid  = vt[v].valid;
      req_data   = 32'hD4C3B2A1;
      force_busy = vt[v].busy;
      #1;
      check($sformatf("vec%0d req_ready", v), 32'(req_ready), 32'(vt[v].exp_ready));
      tick();
      check($sformatf("vec%0d grant", v), 32'(grant), 32'(vt[v].exp_ready));
      check($sformatf("vec%0d tx_start", v), 32'(tx_start), 32'(vt[v].exp_ready != '0));
      check($sformatf("vec%0d tx_data", v), 32'(tx_data), 32'(vt[v].exp_data));
      clear_inputs();
    end

    // Single two-byte message from requester 1, then ptr=2 decides 3 over 0
    do_reset();
    busy_len = 10;
    rq[1].push_back('{8'hA5, 1'b0});
    rq[1].push_back('{8'h3C, 1'b1});
    build_expected();
    run_traffic(200);
    check("single: tx_start pulses", 32'(owners.size()), 32'd2);
    rq[0].push_back('{8'h10, 1'b1});
    rq[3].push_back('{8'h13, 1'b1});
    build_expected();
    run_traffic(200);
    check("single: ptr=2 picks req3 first", 32'(owners.size() > 0 ? owners[0] : -1), 32'd3);

    // Fairness: everyone valid with single-byte messages
    do_reset();
    busy_len = 3;
    for (int i = 0; i < N; i++)
      for (int m = 0; m < 2; m++) rq[i].push_back('{8'(16 * i + m), 1'b1});
    build_expected();
    run_traffic(400);
    check("fair: message count", 32'(owners.size()), 32'd8);
    if (owners.size() >= 5)
      for (int j = 0; j < 5; j++) check($sformatf("fair: grant #%0d", j), 32'(owners[j]), 32'(j % N));

    // No interleave: requester 0 arrives while 2 holds a 3-byte message
    do_reset();
    busy_len = 4;
    rq[2].push_back('{8'h21, 1'b0});
    rq[2].push_back('{8'h22, 1'b0});
    rq[2].push_back('{8'h23, 1'b1});
    rq[0].push_back('{8'h05, 1'b1});
    start_at[0] = 2;
    exq.push_back('{2, 8'h21});
    exq.push_back('{2, 8'h22});
    exq.push_back('{2, 8'h23});
    exq.push_back('{0, 8'h05});
    run_traffic(300);
    exp_own = '{2, 2, 2, 0};
    check("nointerleave: byte count", 32'(owners.size()), 32'd4);
    if (owners.size() == 4)
      for (int j = 0; j < 4; j++) check($sformatf("nointerleave: owner #%0d", j), 32'(owners[j]), 32'(exp_own[j]));
    m_ptr = 1;

    // Gap timeout: owner 3 stalls after a non-last byte
    do_reset();
    busy_len = 3;
    req_valid = 4'b1000;
    req_data[31:24] = 8'h77;
    #1;
    check("gap: accept", 32'(req_ready), 32'(4'b1000));
    tick();
    clear_inputs();
    seen = 1'b0;
    k = 0;
    while (k < 50) begin
      tick();
      k++;
      if (tx_busy) seen = 1'b1;
      else if (seen) break;
    end
    check("gap: owner still granted", 32'(grant), 32'(4'b1000));
    req_valid = 4'b0111;
    leak = '0;
    k = 0;
    while (k < 30) begin
      tick();
      k++;
      if (gap_err) break;
      leak |= req_ready;
    end
    check("gap: err cycles after LOCK entry", 32'(k), 32'd9);
    check("gap: non-owners ignored", 32'(leak), 0);
    check("gap: grant cleared with err", 32'(grant), 0);
    req_valid = 4'b1001;
    #1;
    check("gap: ptr=0 after timeout", 32'(req_ready), 32'(4'b0001));
    tick();
    check("gap: err is one cycle", 32'(gap_err), 0);
    clear_inputs();

    // Simultaneous requests with ptr=1, and busy blocking in IDLE
    do_reset();
    busy_len = 3;
    rq[0].push_back('{8'h44, 1'b1});
    build_expected();
    run_traffic(100);
    force_busy = 1'b1;
    req_valid  = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("simul: busy blocks ready", 32'(req_ready), 0);
      tick();
    end
    force_busy = 1'b0;
    #1;
    check("simul: ptr=1 picks req2", 32'(req_ready), 32'(4'b0100));
    tick();
    clear_inputs();

    // Reset during BUSY_WAIT
    do_reset();
    tx_model_en = 1'b0;
    req_valid = 4'b0100;
    req_data[23:16] = 8'h5A;
    req_last[2] = 1'b1;
    tick();
    clear_inputs();
    check("rst: start before reset", 32'(tx_start), 32'd1);
    tick();
    check("rst: tx_data before reset", 32'(tx_data), 32'h5A);
    check("rst: grant before reset", 32'(grant), 32'(4'b0100));
    req_valid = 4'b0001;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst: grant async", 32'(grant), 0);
    check("rst: tx_start async", 32'(tx_start), 0);
    check("rst: tx_data async", 32'(tx_data), 0);
    check("rst: gap_err async", 32'(gap_err), 0);
    check("rst: req_ready async", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx_model_en = 1'b1;
    m_ptr = 0;
    req_valid = 4'b0101;
    #1;
    check("rst: next grant from ptr=0", 32'(req_ready), 32'(4'b0001));
    tick();
    clear_inputs();

    // Randomized message traffic
    do_reset();
    for (int r = 0; r < 6; r++) begin
      busy_len = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        int nm;
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) add_msg(i, $urandom_range(1, 3));
      end
      add_msg($urandom_range(0, N - 1), 1);
      build_expected();
      run_traffic(2000);
    end
    check("req_ready at most one-hot", 32'(onehot_viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART byte transmitter among `NUM_REQ` requesters. It holds a grant for a whole message, from the first byte to the byte flagged `req_last`, so bytes from different sources never interleave on the line. The transmitter side is a single-byte start/busy handshake. A gap timeout releases a requester that stalls mid-message.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `GAP_TIMEOUT`, default 50000: clock cycles a locked owner may leave `req_valid` low between bytes before its lock is dropped; must be ≥1.

**Ports**
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `req_valid`, in, `NUM_REQ`: per-requester byte available.
- `req_data`, in, `8*NUM_REQ`: byte of requester i on bits [8i+7:8i].
- `req_last`, in, `NUM_REQ`: byte is the last of its message.
- `req_ready`, out, `NUM_REQ`: byte accepted this cycle; combinational; at most one bit set.
- `grant`, out, `NUM_REQ`: one-hot current owner; 0 when unlocked.
- `tx_start`, out, 1: one-cycle pulse that launches the transmitter.
- `tx_data`, out, 8: byte for the transmitter; stable from the `tx_start` cycle until the next accept.
- `tx_busy`, in, 1: transmitter busy, from start bit through end of stop bit.
- `gap_err`, out, 1: one-cycle pulse when a lock is dropped on timeout.

## Operation

- Transfer rule: a byte transfers in any cycle where `req_valid[i] & req_ready[i]`. Data and last flag are latched into `tx_data` and `last_q`.
- **IDLE**, no owner, `grant`=0:
  - If any `req_valid` is high and `tx_busy`=0, the round-robin pick from `ptr` is the winner.
  - `req_ready[winner]`=1 and `grant` takes the winner's one-hot value on the next edge. Go to START.
- **START**: `tx_start`=1 for exactly this cycle. Go to BUSY_WAIT.
- **BUSY_WAIT**: stay until `tx_busy`=1, then go to DONE_WAIT.
- **DONE_WAIT**: stay until `tx_busy`=0.
  - If `last_q`: `ptr` ← owner+1 mod `NUM_REQ`, go to IDLE.
  - Otherwise go to LOCK with the gap counter cleared.
- **LOCK**, owner held:
  - If `req_valid[owner]` and `tx_busy`=0, `req_ready[owner]`=1 and the next state is START.
  - Otherwise the gap counter increments. When it reaches `GAP_TIMEOUT`: pulse `gap_err`, set `ptr` ← owner+1, clear `grant`, go to IDLE.
- Round-robin pick: the first `i` with `req_valid[i]` set, searching `ptr`, `ptr`+1, … with wrap.
- Non-owners never see `req_ready` while a lock is held. Their `req_valid` is ignored.
- An owner may change `req_data` only after its transfer. Bytes presented while it is not ready are not sampled.
- The gap counter is `$clog2(GAP_TIMEOUT+1)` bits wide and saturates; it never wraps.
- Reset values: state IDLE, `ptr`=0, `grant`=0, `tx_start`=0, `tx_data`=0x00, `last_q`=0, gap counter 0, `gap_err`=0, `req_ready`=0.
- Reset mid-message drops the lock immediately. The transmitter is reset independently.

## Timing

- The accept in cycle T (IDLE or LOCK) produces `tx_start` in T+1.
- Minimum spacing between accepts is 1 transfer cycle + START + BUSY_WAIT + the transmitter frame + 1.
- `tx_busy` rising edge: if it already reads 1 during START, BUSY_WAIT exits on its first cycle.
- A requester de-asserting `req_valid` in the cycle after a transfer has no effect on the transferred byte.
- `gap_err` and the `grant`→0 update take effect on the same edge.
- No input is sampled while the state is START, BUSY_WAIT or DONE_WAIT.

## Structure

- Shared package `uart_pkg`: state encoding localparams (IDLE, LOCK, START, BUSY_WAIT, DONE_WAIT; 3-bit). Add the frame-related constants that are also used by the rx/tx blocks.
- Sub-module `uart_rr_pick`: purely combinational.
  - Inputs: `req` [`NUM_REQ`], `ptr`.
  - Outputs: one-hot `winner`, `any`, and the binary index.
- Top module holds the FSM, `ptr`, latches, and gap counter.

## Test plan

- **Single message.** Requester 1 sends 0xA5 (not last), then 0x3C (last); transmitter model holds `tx_busy` 10 cycles per byte.
  - `grant`=0b0010 throughout.
  - `tx_data` is 0xA5 then 0x3C.
  - Two `tx_start` pulses.
  - Returns to IDLE with `ptr`=2.
- **Fairness.** All 4 requesters valid continuously with single-byte messages (`req_last`=1).
  - Grant order 0,1,2,3,0 from reset.
  - No requester is granted twice before every other valid requester has been granted once.
- **No interleave.** Requester 2 holds a 3-byte message while requester 0 is valid throughout.
  - Requester 0 gets no `req_ready` until requester 2's last byte completes.
  - Then `grant`=0b0001.
- **Gap timeout.** `GAP_TIMEOUT`=8; owner 3 sends a non-last byte, then drops `req_valid`.
  - `gap_err` pulses exactly 8 cycles after entering LOCK.
  - `grant`→0, `ptr`=0.
- **Simultaneous requests.** With `ptr`=1 and requesters 0 and 2 valid in the same cycle, requester 2 wins. With `tx_busy`=1 in IDLE, no `req_ready` is issued until it falls.
- **Reset mid-operation.** Assert `rst_n`=0 during BUSY_WAIT.
  - All outputs return to reset values asynchronously.
  - After release, the next request is granted from `ptr`=0.
